// File: rtl/mmio_fifo_ctrl_pkg.sv
// Shared constants, state encoding and STATUS packing for mmio_fifo_ctrl.
package mmio_fifo_pkg;

  localparam int unsigned ADDR_DATA   = 'h0020;
  localparam int unsigned ADDR_STATUS = 'h0022;
  localparam int unsigned ADDR_CTRL   = 'h0024;

  localparam int unsigned CTRL_FLUSH_BIT    = 0;
  localparam int unsigned CTRL_CLR_DROP_BIT = 1;

  localparam int unsigned STATUS_DROP_LSB  = 48;
  localparam int unsigned STATUS_BUSY_BIT  = 32;
  localparam int unsigned STATUS_DEPTH_LSB = 16;
  localparam int unsigned STATUS_FULL_BIT  = 8;
  localparam int unsigned STATUS_FILL_LSB  = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } t_fifo_ctrl_state;

  function automatic logic [63:0] pack_status(input logic [15:0] drop_cnt,
                                              input logic        busy,
                                              input logic [15:0] depth,
                                              input logic        full,
                                              input logic [7:0]  fill);
    logic [63:0] s;
    s                           = '0;
    s[STATUS_DROP_LSB +: 16]    = drop_cnt;
    s[STATUS_BUSY_BIT]          = busy;
    s[STATUS_DEPTH_LSB +: 16]   = depth;
    s[STATUS_FULL_BIT]          = full;
    s[STATUS_FILL_LSB +: 8]     = fill;
    return s;
  endfunction

endpackage

// File: rtl/mmio_fifo_ctrl_if.sv
// MMIO request/response bundle between the CCI-P decode (master) and mmio_fifo_ctrl (slave).
interface mmio_fifo_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16
);
  logic              mmio_wr_valid;
  logic [ADDR_W-1:0] mmio_wr_addr;
  logic [DATA_W-1:0] mmio_wr_data;
  logic              mmio_rd_valid;
  logic [ADDR_W-1:0] mmio_rd_addr;
  logic [8:0]        mmio_rd_tid;
  logic              rsp_valid;
  logic [8:0]        rsp_tid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output mmio_wr_valid, mmio_wr_addr, mmio_wr_data,
    output mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
    input  rsp_valid, rsp_tid, rsp_data
  );

  modport slave (
    input  mmio_wr_valid, mmio_wr_addr, mmio_wr_data,
    input  mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
    output rsp_valid, rsp_tid, rsp_data
  );
endinterface

// File: rtl/mmio_fifo_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAX)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO-driven sequencer for the AFU shift-register FIFO: push decode, flush, read response.
// Optional STATUS register and drop counter are built when MMIO_FIFO_CTRL_STATUS_EN is defined.
module mmio_fifo_ctrl
  import mmio_fifo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  mmio_fifo_ctrl_if.slave   bus,
  output logic              fifo_en,
  output logic [DATA_W-1:0] fifo_d,
  input  logic [DATA_W-1:0] fifo_q,
  output logic              busy
);
  localparam int               FILL_W     = $clog2(DEPTH + 1);
  localparam int               CNT_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(DEPTH - 1);

  t_fifo_ctrl_state  r_state, w_next_state;
  logic [CNT_W-1:0]  r_flush_cnt, w_next_flush_cnt;
  logic              r_fifo_en, w_next_fifo_en;
  logic [DATA_W-1:0] r_fifo_d, w_next_fifo_d;
  logic              r_busy;
  logic              w_push, w_flush_done;
  logic              w_wr_data_hit, w_wr_ctrl_hit, w_flush_req;
  logic [FILL_W-1:0] w_fill;
  logic [63:0]       w_status;
  logic              r_rsp_valid;
  logic [8:0]        r_rsp_tid;
  logic [DATA_W-1:0] r_rsp_data, w_rd_data;

  assign w_wr_data_hit = bus.mmio_wr_valid && (bus.mmio_wr_addr == ADDR_W'(ADDR_DATA));
  assign w_wr_ctrl_hit = bus.mmio_wr_valid && (bus.mmio_wr_addr == ADDR_W'(ADDR_CTRL));
  assign w_flush_req   = w_wr_ctrl_hit && bus.mmio_wr_data[CTRL_FLUSH_BIT];

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state     = r_state;
    w_next_flush_cnt = r_flush_cnt;
    w_next_fifo_en   = 1'b0;
    w_next_fifo_d    = '0;
    w_push           = 1'b0;
    w_flush_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_wr_data_hit) begin
          w_push         = 1'b1;
          w_next_fifo_en = 1'b1;
          w_next_fifo_d  = bus.mmio_wr_data;
        end else if (w_flush_req) begin
          w_next_state     = FLUSH;
          w_next_flush_cnt = '0;
          w_next_fifo_en   = 1'b1;
        end
      end
      FLUSH: begin
        // Flush counter indexes the zero pulse currently on fifo_en.
        if (r_flush_cnt == LAST_FLUSH) begin
          w_next_state     = IDLE;
          w_next_flush_cnt = '0;
          w_flush_done     = 1'b1;
        end else begin
          w_next_flush_cnt = r_flush_cnt + CNT_W'(1);
          w_next_fifo_en   = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_flush_cnt <= w_next_flush_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_en <= 1'b0;
      r_fifo_d  <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_fifo_en <= w_next_fifo_en;
      r_fifo_d  <= w_next_fifo_d;
      r_busy    <= (w_next_state == FLUSH);
    end
  end

  sat_counter #(
    .WIDTH (FILL_W),
    .MAX   (FILL_W'(DEPTH))
  ) u_fill (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_push),
    .i_clr   (w_flush_done),
    .o_count (w_fill)
  );

`ifdef MMIO_FIFO_CTRL_STATUS_EN
  logic        w_drop;
  logic        w_clr_drop;
  logic [15:0] w_drop_cnt;

  assign w_drop     = (r_state == FLUSH) && w_wr_data_hit;
  assign w_clr_drop = w_wr_ctrl_hit && bus.mmio_wr_data[CTRL_CLR_DROP_BIT];

  sat_counter #(
    .WIDTH (16),
    .MAX   (16'hFFFF)
  ) u_drop_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_drop),
    .i_clr   (w_clr_drop),
    .o_count (w_drop_cnt)
  );

  assign w_status = pack_status(w_drop_cnt, r_busy, 16'(DEPTH),
                                (w_fill == FILL_W'(DEPTH)), 8'(w_fill));
`else
  assign w_status = '0;
`endif

  // Response data is captured from pre-edge fifo_q and counters, so a same-cycle push is invisible.
  always_comb begin
    w_rd_data = '0;
    if (bus.mmio_rd_addr == ADDR_W'(ADDR_DATA)) begin
      w_rd_data = fifo_q;
    end else if (bus.mmio_rd_addr == ADDR_W'(ADDR_STATUS)) begin
      w_rd_data = DATA_W'(w_status);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_tid   <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= bus.mmio_rd_valid;
      if (bus.mmio_rd_valid) begin
        r_rsp_tid  <= bus.mmio_rd_tid;
        r_rsp_data <= w_rd_data;
      end
    end
  end

  assign fifo_en       = r_fifo_en;
  assign fifo_d        = r_fifo_d;
  assign busy          = r_busy;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_tid   = r_rsp_tid;
  assign bus.rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Bench for mmio_fifo_ctrl: directed + random MMIO traffic against a cycle-indexed reference model,
// with a scoreboard monitor for read responses and fifo pushes. Honours MMIO_FIFO_CTRL_STATUS_EN.
`timescale 1ns/1ps
module tb_mmio_fifo_ctrl;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 16;
  localparam logic [15:0] A_DATA   = 16'h0020;
  localparam logic [15:0] A_STATUS = 16'h0022;
  localparam logic [15:0] A_CTRL   = 16'h0024;
`ifdef MMIO_FIFO_CTRL_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              fifo_en;
  logic              busy;
  logic [DATA_W-1:0] fifo_d;
  logic [DATA_W-1:0] fifo_q;

  mmio_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mmio_fifo_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .fifo_en (fifo_en),
    .fifo_d  (fifo_d),
    .fifo_q  (fifo_q),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // External shift-register fifo; stage[DEPTH-1] is the oldest entry.
  logic [DATA_W-1:0] stage [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (fifo_en) begin
      for (int i = DEPTH - 1; i > 0; i--) stage[i] <= stage[i-1];
      stage[0] <= fifo_d;
    end
  end
  assign fifo_q = stage[DEPTH-1];

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
  } rsp_t;

  rsp_t        exp_rsp[$];
  logic [63:0] exp_push[$];
  logic [63:0] m_fifo[$];      // index 0 = oldest
  int          m_fill;
  int          m_drop;
  longint      m_cyc;
  longint      m_fs;           // cycle index of the edge that started the last flush
  bit          m_pulse;        // fifo_en expected during the current model cycle
  logic [63:0] m_pulse_d;
  rsp_t        mon_e;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit busy_at(input longint k);
    return (k >= m_fs + 1) && (k <= m_fs + DEPTH);
  endfunction

  function automatic logic [63:0] model_status(input bit b);
    if (!STATUS_EN) return 64'h0;
    return (64'(m_drop) << 48) | (64'(b) << 32) | (64'(DEPTH) << 16) |
           (64'(m_fill == DEPTH) << 8) | 64'(m_fill);
  endfunction

  task automatic model_reset();
    m_fill  = 0;
    m_drop  = 0;
    m_fs    = m_cyc - 1000;
    m_pulse = 1'b0;
    exp_rsp.delete();
    exp_push.delete();
  endtask

  // One clock of stimulus: drive at the negedge, predict what the next posedge does.
  task automatic step(input bit wv, input logic [15:0] wa, input logic [63:0] wd,
                      input bit rv, input logic [15:0] ra, input logic [8:0] tid);
    bit   b;
    rsp_t r;
    @(negedge clk);
    b = busy_at(m_cyc);
    check("busy", 64'(busy), 64'(b));
    bus.mmio_wr_valid = wv;
    bus.mmio_wr_addr  = wa;
    bus.mmio_wr_data  = wd;
    bus.mmio_rd_valid = rv;
    bus.mmio_rd_addr  = ra;
    bus.mmio_rd_tid   = tid;
    if (rv) begin
      r.tid = tid;
      if (ra == A_DATA)        r.data = m_fifo[0];
      else if (ra == A_STATUS) r.data = model_status(b);
      else                     r.data = 64'h0;
      exp_rsp.push_back(r);
    end
    if (m_pulse) begin
      void'(m_fifo.pop_front());
      m_fifo.push_back(m_pulse_d);
    end
    m_pulse   = 1'b0;
    m_pulse_d = 64'h0;
    if (wv && wa == A_DATA) begin
      if (b) begin
        if (m_drop < 'hFFFF) m_drop++;
      end else begin
        if (m_fill < DEPTH) m_fill++;
        m_pulse   = 1'b1;
        m_pulse_d = wd;
      end
    end
    if (wv && wa == A_CTRL) begin
      if (wd[1] && STATUS_EN) m_drop = 0;
      if (wd[0] && !b) m_fs = m_cyc;
    end
    if (m_cyc == m_fs + DEPTH) m_fill = 0;
    if (busy_at(m_cyc + 1)) begin
      m_pulse   = 1'b1;
      m_pulse_d = 64'h0;
    end
    if (m_pulse) exp_push.push_back(m_pulse_d);
    m_cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 64'h0, 1'b0, 16'h0, 9'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    step(1'b1, a, d, 1'b0, 16'h0, 9'h0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [8:0] tid);
    step(1'b0, 16'h0, 64'h0, 1'b1, a, tid);
  endtask

  // Scoreboard monitor: pops on every response pulse and every fifo push.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          check("rsp_unexpected", 64'(bus.rsp_valid), 64'h0);
        end else begin
          mon_e = exp_rsp.pop_front();
          check("rsp_tid", 64'(bus.rsp_tid), 64'(mon_e.tid));
          check("rsp_data", bus.rsp_data, mon_e.data);
        end
      end
      if (fifo_en) begin
        if (exp_push.size() == 0) check("push_unexpected", 64'(fifo_en), 64'h0);
        else check("fifo_d", fifo_d, exp_push.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wa, ra;
    logic [63:0] wd;
    bus.mmio_wr_valid = 1'b0;
    bus.mmio_wr_addr  = '0;
    bus.mmio_wr_data  = '0;
    bus.mmio_rd_valid = 1'b0;
    bus.mmio_rd_addr  = '0;
    bus.mmio_rd_tid   = '0;
    for (int i = 0; i < DEPTH; i++) m_fifo.push_back(64'h0);
    m_cyc = 0;
    model_reset();

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_fifo_en", 64'(fifo_en), 64'h0);
    check("rst_fifo_d", fifo_d, 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_rsp_tid", 64'(bus.rsp_tid), 64'h0);
    check("rst_rsp_data", bus.rsp_data, 64'h0);
    rst = 1'b0;

    // Three consecutive pushes, then fill level.
    wr(A_DATA, 64'h11);
    wr(A_DATA, 64'h22);
    wr(A_DATA, 64'h33);
    idle(1);
    rd(A_STATUS, 9'h001);

    // Overfill to saturation; oldest stage then holds the third write.
    for (int i = 4; i <= 10; i++) wr(A_DATA, 64'(i * 'h11));
    idle(2);
    rd(A_STATUS, 9'h002);
    rd(A_DATA, 9'h003);
    rd(A_CTRL, 9'h004);
    rd(16'h0021, 9'h005);

    // Flush with two writes landing mid-flush.
    wr(A_CTRL, 64'h1);
    idle(1);
    wr(A_DATA, 64'hAAAA);
    idle(2);
    wr(A_DATA, 64'hBBBB);
    wr(A_CTRL, 64'h1);
    rd(A_STATUS, 9'h006);
    idle(4);
    rd(A_STATUS, 9'h007);

    // Simultaneous DATA read and DATA write.
    wr(A_DATA, 64'h5555);
    idle(1);
    step(1'b1, A_DATA, 64'hDEAD_BEEF_0000_0001, 1'b1, A_DATA, 9'h1A5);
    idle(1);
    rd(A_DATA, 9'h1A6);

    // Drop-counter clear.
    wr(A_CTRL, 64'h2);
    rd(A_STATUS, 9'h008);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(7, 0))
        0, 1, 2, 3: wa = A_DATA;
        4:          wa = A_CTRL;
        5:          wa = A_STATUS;
        6:          wa = 16'h0021;
        default:    wa = 16'($urandom);
      endcase
      case ($urandom_range(3, 0))
        0, 1:    ra = A_DATA;
        2:       ra = A_STATUS;
        default: ra = 16'($urandom);
      endcase
      wd = {32'($urandom), 32'($urandom)};
      if (wa == A_CTRL) wd[0] = ($urandom_range(3, 0) == 0);
      step(1'($urandom), wa, wd, 1'($urandom), ra, 9'($urandom));
    end
    idle(DEPTH + 2);

    // Reset during the fourth flush cycle.
    wr(A_CTRL, 64'h1);
    idle(2);
    rd(A_STATUS, 9'h0AA);
    @(posedge clk);
    #2;
    check("pre_rst_busy", 64'(busy), 64'h1);
    check("pre_rst_fifo_en", 64'(fifo_en), 64'h1);
    check("pre_rst_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    rst = 1'b1;
    bus.mmio_rd_valid = 1'b0;
    model_reset();
    #1;
    check("async_rst_busy", 64'(busy), 64'h0);
    check("async_rst_fifo_en", 64'(fifo_en), 64'h0);
    check("async_rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(A_STATUS, 9'h0AB);
    rd(A_DATA, 9'h0AC);
    idle(3);

    check("rsp_queue_drained", 64'(exp_rsp.size()), 64'h0);
    check("push_queue_drained", 64'(exp_push.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_fifo_ctrl.md
# mmio_fifo_ctrl

Controller that sequences the AFU's MMIO-fed shift-register FIFO. It decodes host MMIO writes into FIFO push pulses and runs a multi-cycle flush sequence. It tracks fill level and dropped pushes, and produces the registered MMIO read response for the FIFO data, status and control addresses. It sits between the AFU's CCI-P MMIO decode (request side) and the external `fifo` datapath and `tx.c2` response path.

## Interface
- `DEPTH`, 8: number of FIFO stages; must match the attached fifo.
- `DATA_W`, 64: data width.
- `ADDR_W`, 16: MMIO address width, in 32-bit-word units.
- `clk` in 1: single clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `mmio_wr_valid` in 1: host MMIO write strobe, one cycle per write.
- `mmio_wr_addr` in ADDR_W: write address.
- `mmio_wr_data` in DATA_W: write data.
- `mmio_rd_valid` in 1: host MMIO read strobe.
- `mmio_rd_addr` in ADDR_W: read address.
- `mmio_rd_tid` in 9: read transaction ID.
- `fifo_en` out 1: shift enable to the fifo.
- `fifo_d` out DATA_W: fifo input data.
- `fifo_q` in DATA_W: fifo output, the oldest stage.
- `rsp_valid` out 1: read response valid, one-cycle pulse.
- `rsp_tid` out 9: echoed TID.
- `rsp_data` out DATA_W: read response data.
- `busy` out 1: high while a flush is in progress.

## Operation
- Address map, in word units:
  - 0x0020 DATA: a write pushes; a read returns `fifo_q`.
  - 0x0022 STATUS: read-only.
  - 0x0024 CTRL: write-only; reads return 0.
  - Any other address is ignored on write and returns 0 on read.
- States: IDLE and FLUSH.
- In IDLE:
  - A DATA write drives `fifo_en`=1 and `fifo_d`=`mmio_wr_data` for exactly one cycle.
  - `fill` increments, saturating at DEPTH.
- CTRL bit0 (flush) in IDLE: enter FLUSH.
  - FLUSH issues DEPTH consecutive `fifo_en` pulses with `fifo_d`=0.
  - Then `fill` is set to 0 and the state returns to IDLE.
- CTRL bit1 clears `drop_cnt`; it acts in any state. Bits 0 and 1 set together perform both actions.
- In FLUSH:
  - A DATA write is dropped: no `fifo_en` pulse, and `drop_cnt` increments (16-bit, saturating at 0xFFFF).
  - A flush request is ignored; the flush does not restart.
- STATUS layout:
  - [63:48] `drop_cnt`
  - [32] `busy`
  - [31:16] DEPTH
  - [8] full (`fill`==DEPTH)
  - [7:0] `fill`
- Reads return the same response in every state; reads never stall.
- Reset values of outputs: `fifo_en`=0, `fifo_d`=0, `rsp_valid`=0, `rsp_tid`=0, `rsp_data`=0, `busy`=0.
- Reset values of internal state: state=IDLE, `fill`=0, `drop_cnt`=0, flush counter=0.
- Reset mid-flush aborts to IDLE immediately. The fifo contents are then undefined to software; `fill` reads 0.

## Timing
- All outputs are registered.
- Push: a DATA write sampled at edge N gives `fifo_en` high during cycle N+1.
  - Back-to-back writes give back-to-back pulses.
- Read: a request sampled at edge N gives `rsp_valid`, `rsp_tid` and `rsp_data` during cycle N+1.
  - `rsp_data` is the value of `fifo_q` (or status) sampled at edge N.
- Simultaneous read and write in the same cycle:
  - A DATA read returns the pre-shift `fifo_q`.
  - A STATUS read returns the pre-update `fill`/`drop_cnt`.
- Flush: a CTRL write at edge N sets `busy` and `fifo_en` high during cycles N+1..N+DEPTH.
  - `busy` falls and `fill`=0 in cycle N+DEPTH+1.
  - A DATA write sampled at edge N+DEPTH+1 or later is accepted normally.
- Write and read strobes may both be asserted every cycle; there is no backpressure.

## Configuration
- `MMIO_FIFO_CTRL_STATUS_EN` defined:
  - STATUS register and `drop_cnt` are implemented as above.
- Undefined:
  - STATUS reads return 0.
  - `drop_cnt` logic is removed, and CTRL bit1 is ignored.
  - Pushes during FLUSH are still dropped.
  - `busy`, `fill` and flush behaviour are unchanged.

## Structure
- Package `mmio_fifo_pkg` holds:
  - Address constants `ADDR_DATA`, `ADDR_STATUS`, `ADDR_CTRL`.
  - The state enum `t_fifo_ctrl_state` (IDLE, FLUSH).
  - The CTRL bit positions and STATUS field offsets.
- One sub-module, `sat_counter` (parameterized width and max, with inc and clr), used for `fill` and `drop_cnt`.
- The FSM and the response mux live in the top module.

## Test plan
- Reset, then 3 DATA writes 0x11, 0x22, 0x33 on consecutive cycles: exactly 3 consecutive `fifo_en` pulses carrying those values; STATUS reads `fill`=3, full=0.
- 10 DATA writes with DEPTH=8: `fill` saturates at 8, full=1; a DATA read returns the 3rd written value, sampled before any further shift.
- CTRL=0x1, then DATA writes at cycles +2 and +5: 8 zero pushes; both writes dropped, `drop_cnt`=2; `busy` high for 8 cycles; afterwards `fill`=0.
- Read of DATA and write of DATA in the same cycle with tid=0x1A5: response the next cycle with tid 0x1A5 and the pre-shift `fifo_q`.
- `rst` asserted during the 4th flush cycle: `busy`, `fifo_en` and `rsp_valid` drop asynchronously; after release, STATUS=DEPTH<<16 only.
- Build without `MMIO_FIFO_CTRL_STATUS_EN`: STATUS read returns 0 and CTRL=0x2 has no effect; flush still issues DEPTH pulses.
